// File: rtl/riscv_defines.sv
// riscv_defines: shared types and constants for the memory stage.
// Provides the M1 memory-op encoding, store-size funct3 codes and the
// store-buffer entry layout used by mem_store_buffer.
package riscv_defines;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } memaccess_t;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // One buffered store: word address, lane-aligned data, byte strobes.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [3:0]      strb;
    } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// store_align: combinational byte-lane alignment of store data.
// Ports:
//   funct3 - store size (SB/SH/SW; anything else behaves as SW)
//   off    - byte offset within the word (addr[1:0])
//   data   - raw store data
//   wdata  - data replicated across lanes
//   wstrb  - byte strobes; lanes shifted past bit 3 are dropped
module store_align
    import riscv_defines::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      wstrb
);

    always_comb begin
        wdata = data;
        wstrb = 4'b1111;
        case (funct3)
            F3_SB: begin
                wdata = {(XLEN/8){data[7:0]}};
                wstrb = 4'b0001 << off;
            end
            F3_SH: begin
                wdata = {(XLEN/16){data[15:0]}};
                // Misaligned halves lose the lane that falls off bit 3.
                wstrb = 4'b0011 << off;
            end
            default: begin
                wdata = data;
                wstrb = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: M1-stage store buffer.
// Selects store data (forwarded W result or rs2), aligns it to byte lanes,
// queues it in a DEPTH-entry FIFO and drains to the data-memory write port.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   memaccess_m1 ...      - M1 memory op, size, address, data, forward select
//   result_w              - W-stage writeback value
//   hold_m1, flush_m1     - M1 held / squashed
//   dmem_w*               - write port; valid/ready: a request raised with
//                           dmem_wvalid holds addr/data/strb unchanged until
//                           the cycle dmem_wready is also high
//   sb_stall              - store into full buffer, or load hitting a pending
//                           store word
//   sb_empty              - no pending stores
module mem_store_buffer
    import riscv_defines::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  memaccess_t      memaccess_m1,
    input  logic [2:0]      funct3_m1,
    input  logic [XLEN-1:0] addr_m1,
    input  logic [XLEN-1:0] rs2_data_m1,
    input  logic            forward_m1,
    input  logic [XLEN-1:0] result_w,
    input  logic            hold_m1,
    input  logic            flush_m1,
    output logic            dmem_wvalid,
    output logic [XLEN-1:0] dmem_waddr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_wready,
    output logic            sb_stall,
    output logic            sb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [DEPTH-1:0] ent_valid;
    logic [XLEN-3:0] ent_word [DEPTH];
    logic [XLEN-1:0] ent_data [DEPTH];
    logic [3:0]      ent_strb [DEPTH];

    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] align_wdata;
    logic [3:0]      align_wstrb;
    logic            full;
    logic            addr_hit;
    logic            store_stall;
    logic            load_stall;
    logic            enq;
    logic            deq;

    assign store_data = forward_m1 ? result_w : rs2_data_m1;

    store_align #(.XLEN(XLEN)) u_align (
        .funct3 (funct3_m1),
        .off    (addr_m1[1:0]),
        .data   (store_data),
        .wdata  (align_wdata),
        .wstrb  (align_wstrb)
    );

    // Word-granular match against every live entry.
    always_comb begin
        addr_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && ent_word[i] == addr_m1[XLEN-1:2]) begin
                addr_hit = 1'b1;
            end
        end
    end

    // full is the pre-dequeue occupancy, so sb_stall never depends on wready.
    assign full        = (count == FULL_COUNT);
    assign store_stall = (memaccess_m1 == MEM_WRITE) && full && !flush_m1;
    assign load_stall  = (memaccess_m1 == MEM_READ) && !flush_m1 && addr_hit;
    assign sb_stall    = store_stall | load_stall;

    assign enq = (memaccess_m1 == MEM_WRITE) && !flush_m1 && !hold_m1 && !full;
    assign deq = dmem_wvalid && dmem_wready;

    assign sb_empty    = (count == '0);
    assign dmem_wvalid = !sb_empty;
    assign dmem_waddr  = {ent_word[head], 2'b00};
    assign dmem_wdata  = ent_data[head];
    assign dmem_wstrb  = ent_strb[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_word[i] <= '0;
                ent_data[i] <= '0;
                ent_strb[i] <= '0;
            end
        end else begin
            // enq and deq never target the same slot: enq needs !full and
            // deq needs !empty, so tail == head cannot occur with both.
            if (enq) begin
                ent_word[tail]  <= addr_m1[XLEN-1:2];
                ent_data[tail]  <= align_wdata;
                ent_strb[tail]  <= align_wstrb;
                ent_valid[tail] <= 1'b1;
                tail            <= tail + 1'b1;
            end
            if (deq) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// tb_mem_store_buffer: directed plus randomized bench for mem_store_buffer
// against a queue-based reference model of the store buffer.
module tb_mem_store_buffer;
    import riscv_defines::*;

    localparam int XW    = 32;
    localparam int DEPTH = 4;
    localparam int W     = XW + XW + 4;

    logic            clk = 1'b0;
    logic            reset;
    memaccess_t      memaccess_m1;
    logic [2:0]      funct3_m1;
    logic [XW-1:0]   addr_m1;
    logic [XW-1:0]   rs2_data_m1;
    logic            forward_m1;
    logic [XW-1:0]   result_w;
    logic            hold_m1;
    logic            flush_m1;
    logic            dmem_wvalid;
    logic [XW-1:0]   dmem_waddr;
    logic [XW-1:0]   dmem_wdata;
    logic [3:0]      dmem_wstrb;
    logic            dmem_wready;
    logic            sb_stall;
    logic            sb_empty;

    int vec_count = 0;
    int err_count = 0;

    // Model: each entry {word address, lane data, strobes}, oldest first.
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    mem_store_buffer #(.DEPTH(DEPTH), .XLEN(XW)) dut (
        .clk          (clk),
        .reset        (reset),
        .memaccess_m1 (memaccess_m1),
        .funct3_m1    (funct3_m1),
        .addr_m1      (addr_m1),
        .rs2_data_m1  (rs2_data_m1),
        .forward_m1   (forward_m1),
        .result_w     (result_w),
        .hold_m1      (hold_m1),
        .flush_m1     (flush_m1),
        .dmem_wvalid  (dmem_wvalid),
        .dmem_waddr   (dmem_waddr),
        .dmem_wdata   (dmem_wdata),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_wready  (dmem_wready),
        .sb_stall     (sb_stall),
        .sb_empty     (sb_empty)
    );

    task automatic check(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_entry(input logic [2:0] f3, input logic [XW-1:0] addr,
                                                 input logic [XW-1:0] data);
        logic [XW-1:0] wd;
        logic [3:0]    st;
        case (f3)
            3'b000: begin
                wd = {24'b0, data[7:0]} * 32'h0101_0101;
                case (addr[1:0])
                    2'd0: st = 4'b0001;
                    2'd1: st = 4'b0010;
                    2'd2: st = 4'b0100;
                    default: st = 4'b1000;
                endcase
            end
            3'b001: begin
                wd = {16'b0, data[15:0]} * 32'h0001_0001;
                case (addr[1:0])
                    2'd0: st = 4'b0011;
                    2'd1: st = 4'b0110;
                    2'd2: st = 4'b1100;
                    default: st = 4'b1000;
                endcase
            end
            default: begin
                wd = data;
                st = 4'b1111;
            end
        endcase
        return {addr & 32'hFFFF_FFFC, wd, st};
    endfunction

    task automatic set_idle();
        memaccess_m1 = MEM_NONE;
        funct3_m1    = 3'b010;
        addr_m1      = '0;
        rs2_data_m1  = '0;
        forward_m1   = 1'b0;
        result_w     = '0;
        hold_m1      = 1'b0;
        flush_m1     = 1'b0;
        reset        = 1'b0;
    endtask

    task automatic set_op(input memaccess_t m, input logic [2:0] f3, input logic [XW-1:0] a,
                          input logic [XW-1:0] d);
        set_idle();
        memaccess_m1 = m;
        funct3_m1    = f3;
        addr_m1      = a;
        rs2_data_m1  = d;
    endtask

    // Called at a negedge with inputs set; checks, advances one clock,
    // updates the model and returns at the following negedge.
    task automatic cycle();
        logic          full;
        logic          hit;
        logic          exp_stall;
        logic          do_enq;
        logic          do_deq;
        logic [W-1:0]  e;
        logic [XW-1:0] sel;
        #1;
        full = (exp_q.size() == DEPTH);
        hit  = 1'b0;
        foreach (exp_q[i]) begin
            e = exp_q[i];
            if (e[W-1 -: XW-2] == addr_m1[XW-1:2]) hit = 1'b1;
        end
        exp_stall = ((memaccess_m1 == MEM_WRITE) && full && !flush_m1) ||
                    ((memaccess_m1 == MEM_READ) && !flush_m1 && hit);
        check("sb_stall", {31'b0, sb_stall}, {31'b0, exp_stall});
        check("sb_empty", {31'b0, sb_empty}, {31'b0, exp_q.size() == 0});
        check("wvalid", {31'b0, dmem_wvalid}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            check("waddr", dmem_waddr, e[W-1 -: XW]);
            check("wdata", dmem_wdata, e[XW+3:4]);
            check("wstrb", {28'b0, dmem_wstrb}, {28'b0, e[3:0]});
        end
        do_enq = (memaccess_m1 == MEM_WRITE) && !flush_m1 && !hold_m1 && !full;
        do_deq = (exp_q.size() != 0) && dmem_wready;
        sel    = forward_m1 ? result_w : rs2_data_m1;
        e      = model_entry(funct3_m1, addr_m1, sel);
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
        end else begin
            if (do_deq) void'(exp_q.pop_front());
            if (do_enq) exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        reset       = 1'b1;
        dmem_wready = 1'b0;
        @(negedge clk);
        cycle();
        reset = 1'b1;
        cycle();
        set_idle();
        #1;
        check("rst_wvalid", {31'b0, dmem_wvalid}, 32'd0);
        check("rst_empty", {31'b0, sb_empty}, 32'd1);
        check("rst_stall", {31'b0, sb_stall}, 32'd0);
        check("rst_waddr", dmem_waddr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_wstrb", {28'b0, dmem_wstrb}, 32'd0);
        @(negedge clk);

        // Forwarded store data.
        dmem_wready = 1'b1;
        set_op(MEM_WRITE, F3_SW, 32'h100, 32'h1111_1111);
        forward_m1 = 1'b1;
        result_w   = 32'hDEAD_BEEF;
        cycle();
        set_idle();
        #1;
        check("fwd_wvalid", {31'b0, dmem_wvalid}, 32'd1);
        check("fwd_waddr", dmem_waddr, 32'h100);
        check("fwd_wdata", dmem_wdata, 32'hDEAD_BEEF);
        check("fwd_wstrb", {28'b0, dmem_wstrb}, 32'hF);
        cycle();

        // Byte and half alignment.
        dmem_wready = 1'b0;
        set_op(MEM_WRITE, F3_SB, 32'h203, 32'h0000_00AB);
        cycle();
        set_idle();
        #1;
        check("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        check("sb_wstrb", {28'b0, dmem_wstrb}, 32'h8);
        dmem_wready = 1'b1;
        cycle();
        dmem_wready = 1'b0;
        set_op(MEM_WRITE, F3_SH, 32'h202, 32'h0000_1234);
        cycle();
        set_idle();
        #1;
        check("sh_wdata", dmem_wdata, 32'h1234_1234);
        check("sh_wstrb", {28'b0, dmem_wstrb}, 32'hC);
        dmem_wready = 1'b1;
        cycle();

        // Fill, stall the fifth store, then drain under it.
        dmem_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_op(MEM_WRITE, F3_SW, 32'(i * 4), 32'(32'hA0 + i));
            cycle();
        end
        set_op(MEM_WRITE, F3_SW, 32'h10, 32'hA4);
        #1;
        check("full_stall", {31'b0, sb_stall}, 32'd1);
        cycle();
        cycle();
        dmem_wready = 1'b1;
        cycle();
        cycle();
        set_idle();
        for (int i = 0; i < 6; i++) cycle();

        // Load hazard against a pending store.
        dmem_wready = 1'b0;
        set_op(MEM_WRITE, F3_SW, 32'h40, 32'h5555_AAAA);
        cycle();
        set_op(MEM_READ, F3_SW, 32'h42, 32'h0);
        #1;
        check("ld_hit", {31'b0, sb_stall}, 32'd1);
        cycle();
        set_op(MEM_READ, F3_SW, 32'h44, 32'h0);
        #1;
        check("ld_miss", {31'b0, sb_stall}, 32'd0);
        cycle();
        set_idle();
        dmem_wready = 1'b1;
        cycle();
        cycle();
        set_op(MEM_READ, F3_SW, 32'h42, 32'h0);
        #1;
        check("ld_drained", {31'b0, sb_stall}, 32'd0);
        cycle();

        // Flush and hold suppress enqueue.
        dmem_wready = 1'b0;
        set_op(MEM_WRITE, F3_SW, 32'h80, 32'h1);
        flush_m1 = 1'b1;
        cycle();
        set_op(MEM_WRITE, F3_SW, 32'h84, 32'h2);
        hold_m1 = 1'b1;
        cycle();
        cycle();
        #1;
        check("hold_empty", {31'b0, sb_empty}, 32'd1);
        hold_m1 = 1'b0;
        cycle();
        set_idle();
        cycle();
        dmem_wready = 1'b1;
        cycle();
        cycle();

        // Reset while stores are pending.
        dmem_wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(MEM_WRITE, F3_SW, 32'(32'h300 + i * 4), 32'(i));
            cycle();
        end
        set_idle();
        reset = 1'b1;
        cycle();
        set_idle();
        #1;
        check("rst_mid_wvalid", {31'b0, dmem_wvalid}, 32'd0);
        check("rst_mid_empty", {31'b0, sb_empty}, 32'd1);
        dmem_wready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic over a small address window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            set_idle();
            memaccess_m1 = memaccess_t'($urandom_range(0, 2));
            funct3_m1    = 3'($urandom_range(0, 7));
            addr_m1      = 32'($urandom_range(0, 63));
            rs2_data_m1  = $urandom;
            result_w     = $urandom;
            forward_m1   = 1'($urandom_range(0, 1));
            hold_m1      = ($urandom_range(0, 7) == 0);
            flush_m1     = ($urandom_range(0, 7) == 0);
            reset        = ($urandom_range(0, 199) == 0);
            dmem_wready  = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
